// File: rtl/bcd_display_scan.sv
// -----------------------------------------------------------------------------
// bcd_display_scan
//
// Purpose:
//   Latches the ALU's tens/units BCD digits together with its zero and error
//   flags. It then time-multiplexes the two digits onto a 2-digit 7-segment
//   display. Between digits there is a short all-dark guard gap, which
//   prevents ghosting. A leading zero in the tens position is blanked, and an
//   error result is shown as the glyph "Er". All pad-facing outputs come
//   straight from flops.
//
// Scan order (one counter, cleared on every state change):
//   S_TENS (REFRESH_DIV) -> S_GAP1 (GUARD_CYC) -> S_UNITS (REFRESH_DIV)
//   -> S_GAP0 (GUARD_CYC) -> S_TENS ...
//
// Optional feature macro:
//   ERR_BLINK_EN - when defined, a latched error blinks the display. The
//                  display toggles between lit and dark every BLINK_SCANS full
//                  scans. When undefined, the "Er" glyph is shown steadily.
//
// Parameters:
//   REFRESH_DIV  clk cycles each digit is lit per scan (>= 2)
//   GUARD_CYC    clk cycles of darkness between digits (>= 1)
//   BLINK_SCANS  full scans per blink half-period (ERR_BLINK_EN only)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous reset, active-low
//   load      1-cycle strobe capturing dec_bin/unis_bin/zero/error
//   dec_bin   tens digit (10-15 shown as a dash)
//   unis_bin  units digit (10-15 shown as a dash)
//   zero      ALU zero flag
//   error     ALU error flag
//   seg       segments {g,f,e,d,c,b,a}, active-high
//   dig_en    anode enables {tens,units}, active-high, never both set
//   zero_led  latched zero flag
//   err_led   latched error flag
// -----------------------------------------------------------------------------
module bcd_display_scan #(
  parameter int REFRESH_DIV = 1000,
  parameter int GUARD_CYC   = 2,
  parameter int BLINK_SCANS = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] dec_bin,
  input  logic [3:0] unis_bin,
  input  logic       zero,
  input  logic       error,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       zero_led,
  output logic       err_led
);

  localparam int MAX_CYC = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] REF_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_R = 7'h50;

  typedef enum logic [1:0] {
    S_TENS  = 2'd0,
    S_GAP1  = 2'd1,
    S_UNITS = 2'd2,
    S_GAP0  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;

  logic [3:0] dec_reg, unis_reg;
  logic       zero_reg, error_reg;

  logic [6:0] seg_reg, seg_next;
  logic [1:0] dig_en_reg, dig_en_next;
  logic       zero_led_reg, err_led_reg;

  logic       blink_dark;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // non-decimal value: dash
    endcase
    return s;
  endfunction

  // Shadow registers. A load does not disturb the scan; new data simply
  // appears in whichever digit is active on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_reg   <= '0;
      unis_reg  <= '0;
      zero_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else if (load) begin
      dec_reg   <= dec_bin;
      unis_reg  <= unis_bin;
      zero_reg  <= zero;
      error_reg <= error;
    end
  end

  // Scan FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_TENS;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Scan FSM: next state.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg + 1'b1;
    case (state_reg)
      S_TENS: if (count_reg == REF_LAST) begin
        state_next = S_GAP1;
        count_next = '0;
      end
      S_GAP1: if (count_reg == GUARD_LAST) begin
        state_next = S_UNITS;
        count_next = '0;
      end
      S_UNITS: if (count_reg == REF_LAST) begin
        state_next = S_GAP0;
        count_next = '0;
      end
      S_GAP0: if (count_reg == GUARD_LAST) begin
        state_next = S_TENS;
        count_next = '0;
      end
      default: begin
        state_next = S_TENS;
        count_next = '0;
      end
    endcase
  end

`ifdef ERR_BLINK_EN
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

  logic [BW-1:0] blink_cnt_reg;
  logic          blink_phase_reg;
  logic          scan_wrap;

  // The last gap cycle ends a full scan.
  assign scan_wrap = (state_reg == S_GAP0) && (count_reg == GUARD_LAST);

  // Blink state restarts on every load, so a fresh error always begins lit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (load) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (scan_wrap && error_reg) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign blink_dark = blink_phase_reg;
`else
  // Blinking is not built in. The comparison is constantly false and only
  // keeps BLINK_SCANS referenced so the parameter list is the same in both
  // builds.
  assign blink_dark = (BLINK_SCANS < 0);
`endif

  // Output decode for the cycle now in progress, registered below. Dark
  // (dig_en=00) always comes with seg=00.
  always_comb begin
    seg_next    = 7'h00;
    dig_en_next = 2'b00;
    case (state_reg)
      S_TENS: begin
        if (error_reg) begin
          seg_next    = GLYPH_E;
          dig_en_next = 2'b10;
        end else if (dec_reg != 4'd0) begin
          seg_next    = seg_decode(dec_reg);
          dig_en_next = 2'b10;
        end
      end
      S_UNITS: begin
        seg_next    = error_reg ? GLYPH_R : seg_decode(unis_reg);
        dig_en_next = 2'b01;
      end
      default: begin
        seg_next    = 7'h00;
        dig_en_next = 2'b00;
      end
    endcase
    if (blink_dark) begin
      seg_next    = 7'h00;
      dig_en_next = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_reg      <= 7'h00;
      dig_en_reg   <= 2'b00;
      zero_led_reg <= 1'b0;
      err_led_reg  <= 1'b0;
    end else begin
      seg_reg      <= seg_next;
      dig_en_reg   <= dig_en_next;
      zero_led_reg <= zero_reg;
      err_led_reg  <= error_reg;
    end
  end

  assign seg      = seg_reg;
  assign dig_en   = dig_en_reg;
  assign zero_led = zero_led_reg;
  assign err_led  = err_led_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scan
//
// Purpose:
//   Self-checking bench for bcd_display_scan. A reference model predicts every
//   cycle's registered outputs. It works from the position inside the scan
//   period, counted from reset release, and from the most recently loaded
//   digits and flags. Directed steps are mixed with random loads and resets.
// -----------------------------------------------------------------------------
module tb_bcd_display_scan;

  localparam int R = 4;
  localparam int G = 1;
  localparam int B = 2;
  localparam int P = 2 * R + 2 * G;

`ifdef ERR_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] dec_bin;
  logic [3:0] unis_bin;
  logic       zero;
  logic       error;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       zero_led;
  logic       err_led;

  always #5 clk = ~clk;

  bcd_display_scan #(
    .REFRESH_DIV(R),
    .GUARD_CYC  (G),
    .BLINK_SCANS(B)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .dec_bin (dec_bin),
    .unis_bin(unis_bin),
    .zero    (zero),
    .error   (error),
    .seg     (seg),
    .dig_en  (dig_en),
    .zero_led(zero_led),
    .err_led (err_led)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         t;       // edges since reset release
  int         wraps;   // full scans completed since last load or reset
  logic [3:0] m_dec, m_unis;
  logic       m_zero, m_err;
  logic [6:0] glyph [16];
  logic [6:0] exp_seg;
  logic [1:0] exp_dig;
  logic       exp_zl, exp_el;

  // One clock cycle: drive inputs, predict what this edge registers, then check.
  task automatic cyc(input logic r, input logic ld, input logic [3:0] d,
                     input logic [3:0] u, input logic z, input logic e);
    int pos;
    bit dark;
    rst_n    = r;
    load     = ld;
    dec_bin  = d;
    unis_bin = u;
    zero     = z;
    error    = e;
    @(posedge clk);
    if (!r) begin
      exp_seg = 7'h00;
      exp_dig = 2'b00;
      exp_zl  = 1'b0;
      exp_el  = 1'b0;
      t       = 0;
      wraps   = 0;
      m_dec   = 4'd0;
      m_unis  = 4'd0;
      m_zero  = 1'b0;
      m_err   = 1'b0;
    end else begin
      pos     = t % P;
      exp_zl  = m_zero;
      exp_el  = m_err;
      exp_seg = 7'h00;
      exp_dig = 2'b00;
      if (pos < R) begin
        if (m_err) begin
          exp_seg = 7'h79;
          exp_dig = 2'b10;
        end else if (m_dec != 4'd0) begin
          exp_seg = glyph[m_dec];
          exp_dig = 2'b10;
        end
      end else if (pos >= R + G && pos < 2 * R + G) begin
        exp_seg = m_err ? 7'h50 : glyph[m_unis];
        exp_dig = 2'b01;
      end
      dark = BLINK_ON && m_err && (((wraps / B) % 2) == 1);
      if (dark) begin
        exp_seg = 7'h00;
        exp_dig = 2'b00;
      end
      if (pos == P - 1) wraps++;
      t++;
      if (ld) begin
        m_dec  = d;
        m_unis = u;
        m_zero = z;
        m_err  = e;
        wraps  = 0;
      end
    end
    #1;
    checks++;
    assert (seg === exp_seg) else begin
      errors++;
      $error("FAIL seg t=%0d observed %h expected %h", t, seg, exp_seg);
    end
    checks++;
    assert (dig_en === exp_dig) else begin
      errors++;
      $error("FAIL dig_en t=%0d observed %b expected %b", t, dig_en, exp_dig);
    end
    checks++;
    assert (zero_led === exp_zl) else begin
      errors++;
      $error("FAIL zero_led t=%0d observed %b expected %b", t, zero_led, exp_zl);
    end
    checks++;
    assert (err_led === exp_el) else begin
      errors++;
      $error("FAIL err_led t=%0d observed %b expected %b", t, err_led, exp_el);
    end
  endtask

  // Cycles with load low but random data on the other inputs, which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Advance until the next edge is at the given position within the scan.
  task automatic align(input int target);
    for (int i = 0; i < P && (t % P) != target; i++) idle(1);
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    t = 0; wraps = 0;
    m_dec = 4'd0; m_unis = 4'd0; m_zero = 1'b0; m_err = 1'b0;
    rst_n = 1'b0; load = 1'b0; dec_bin = 4'd0; unis_bin = 4'd0;
    zero = 1'b0; error = 1'b0;

    // 1: reset held with random inputs
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    // 2: digits 4 and 2
    cyc(1'b1, 1'b1, 4'd4, 4'd2, 1'b0, 1'b0);
    idle(20);

    // 3: leading-zero blanking, then zero result
    cyc(1'b1, 1'b1, 4'd0, 4'd7, 1'b0, 1'b0);
    idle(12);
    cyc(1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(12);

    // 4: error glyph (blinks when the feature is built in)
    cyc(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
    idle(70);

    // 5: non-decimal digits, then a load in the middle of the units phase
    cyc(1'b1, 1'b1, 4'hA, 4'hC, 1'b0, 1'b0);
    idle(8);
    align(R + G + 1);
    cyc(1'b1, 1'b1, 4'd3, 4'd8, 1'b0, 1'b0);
    idle(12);

    // 6: one-cycle reset during the units phase
    align(R + G + 2);
    cyc(1'b0, 1'b1, 4'($urandom), 4'($urandom), 1'b1, 1'b1);
    idle(15);

    // 7: random loads and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0)
        cyc(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      else if ($urandom_range(0, 7) == 0)
        cyc(1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) == 0));
      else
        idle(1);
    end

    // long random error run to exercise several blink periods
    cyc(1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
